cdb_writeback_arbiter: RTL and testbench

Producer end of the scoreboard register-write clear interface. Merges ALU and MEM completions into one registered common data bus (CDB) writeback per cycle. Each writeback drives the register-file write and the per-warp scoreboard clear pair (Clear_Valid_regwr / Clear_ScbID_regwr). Sits between the execute/memory pipes and the register file plus per-warp scoreboards.

---
 rtl/gpu_pkg.sv | 40 ++++
 rtl/wb_fifo.sv | 72 +++++++
 rtl/cdb_writeback_arbiter.sv | 142 ++++++++++++++
 tb/tb_cdb_writeback_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU core definitions for the writeback path.
// Holds warp/scoreboard/register geometry, the writeback request payload
// and the one-hot warp decode used by the scoreboard clear interface.
package gpu_pkg;

    localparam int unsigned NUM_WARPS  = 8;
    localparam int unsigned WARP_ID_W  = 3;
    localparam int unsigned SCB_ID_W   = 2;
    localparam int unsigned REG_ID_W   = 5;
    localparam int unsigned NUM_LANES  = 8;
    localparam int unsigned DATA_W     = NUM_LANES * 32;

    // MEM-side writeback buffer geometry (depth must be a power of 2)
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;

    // One register-file writeback plus the scoreboard entry it retires
    typedef struct packed {
        logic [WARP_ID_W-1:0] warp_id;
        logic [SCB_ID_W-1:0]  scb_id;
        logic [REG_ID_W-1:0]  dst;
        logic [NUM_LANES-1:0] mask;
        logic [DATA_W-1:0]    data;
    } wb_req_t;

    // One-hot warp select, all-zero when not enabled
    function automatic logic [NUM_WARPS-1:0] warp_onehot(
        input logic [WARP_ID_W-1:0] warp_id,
        input logic                 en
    );
        logic [NUM_WARPS-1:0] v;
        v = '0;
        if (en) begin
            v[warp_id] = 1'b1;
        end
        return v;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests buffering MEM results while the
// ALU owns the CDB. Head entry is presented combinationally.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset (clears pointers/count)
//   i_push       enqueue i_din (ignored when full)
//   i_pop        dequeue head (ignored when empty)
//   i_din        request to enqueue
//   o_dout_c     current head entry (valid when !o_empty_c)
//   o_count      registered occupancy, 0..FIFO_DEPTH
//   o_full_c     occupancy == FIFO_DEPTH
//   o_empty_c    occupancy == 0
module wb_fifo
    import gpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  wb_req_t               i_din,
    output wb_req_t               o_dout_c,
    output logic [FIFO_CNT_W-1:0] o_count,
    output logic                  o_full_c,
    output logic                  o_empty_c
);

    wb_req_t               r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] r_wr_ptr;
    logic [FIFO_PTR_W-1:0] r_rd_ptr;
    logic [FIFO_CNT_W-1:0] r_count;

    logic                  w_push;
    logic                  w_pop;

    // Full/empty come from the registered count only
    assign o_full_c  = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
    assign o_empty_c = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout_c  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full_c;
    assign w_pop  = i_pop  & ~o_empty_c;

    // Payload storage; contents are meaningless once the pointers reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because the depth is a power of 2
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + FIFO_CNT_W'(1);
                2'b01:   r_count <= r_count - FIFO_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// Common data bus writeback arbiter. Merges ALU and MEM completions into
// one registered writeback per cycle, driving the register-file write and
// the per-warp scoreboard clear pair in the same cycle. The ALU cannot
// stall and always wins; MEM results queue in a small FIFO and drain in
// order whenever the ALU is idle.
//
// Build option: define CDB_BYPASS_EN to let a MEM result skip the empty
// FIFO and reach the output register one cycle after acceptance.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   alu_*                    ALU result (valid, warp, scb entry, dst, mask, data)
//   mem_valid / mem_ready    MEM result handshake; mem_* carry the payload
//   cdb_*                    registered writeback (valid, warp, dst, mask, data)
//   clear_valid_regwr        one-hot per-warp scoreboard clear
//   clear_scb_id_regwr       scoreboard entry being cleared
//   fifo_count               MEM buffer occupancy
module cdb_writeback_arbiter
    import gpu_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  alu_valid,
    input  logic [WARP_ID_W-1:0]  alu_warp_id,
    input  logic [SCB_ID_W-1:0]   alu_scb_id,
    input  logic [REG_ID_W-1:0]   alu_dst,
    input  logic [NUM_LANES-1:0]  alu_mask,
    input  logic [DATA_W-1:0]     alu_data,

    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [WARP_ID_W-1:0]  mem_warp_id,
    input  logic [SCB_ID_W-1:0]   mem_scb_id,
    input  logic [REG_ID_W-1:0]   mem_dst,
    input  logic [NUM_LANES-1:0]  mem_mask,
    input  logic [DATA_W-1:0]     mem_data,

    output logic                  cdb_valid,
    output logic [WARP_ID_W-1:0]  cdb_warp_id,
    output logic [REG_ID_W-1:0]   cdb_dst,
    output logic [NUM_LANES-1:0]  cdb_mask,
    output logic [DATA_W-1:0]     cdb_data,

    output logic [NUM_WARPS-1:0]  clear_valid_regwr,
    output logic [SCB_ID_W-1:0]   clear_scb_id_regwr,

    output logic [FIFO_CNT_W-1:0] fifo_count
);

    wb_req_t               w_alu_req;
    wb_req_t               w_mem_req;
    wb_req_t               w_head_req;
    wb_req_t               w_sel_req;
    logic                  w_sel_valid;
    logic                  w_mem_acc;
    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [FIFO_CNT_W-1:0] w_fifo_count;

    wb_req_t               r_cdb;
    logic                  r_cdb_valid;
    logic [NUM_WARPS-1:0]  r_clear_valid;
    logic [SCB_ID_W-1:0]   r_clear_scb;

    assign w_alu_req = '{warp_id: alu_warp_id, scb_id: alu_scb_id, dst: alu_dst,
                         mask: alu_mask, data: alu_data};
    assign w_mem_req = '{warp_id: mem_warp_id, scb_id: mem_scb_id, dst: mem_dst,
                         mask: mem_mask, data: mem_data};

    // Ready depends only on registered occupancy: a same-cycle dequeue
    // does not reopen a full buffer, which keeps mem_ready off any comb path.
    assign mem_ready = ~w_fifo_full;
    assign w_mem_acc = mem_valid & mem_ready;

`ifdef CDB_BYPASS_EN
    // Idle ALU and nothing buffered: MEM result goes straight to the CDB
    assign w_bypass = w_mem_acc & w_fifo_empty & ~alu_valid;
`else
    assign w_bypass = 1'b0;
`endif

    // Writeback source select: ALU, then FIFO head, then (optionally) bypass
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_req   = '0;
        w_pop       = 1'b0;
        w_push      = w_mem_acc;
        if (alu_valid) begin
            w_sel_valid = 1'b1;
            w_sel_req   = w_alu_req;
        end else if (!w_fifo_empty) begin
            w_sel_valid = 1'b1;
            w_sel_req   = w_head_req;
            w_pop       = 1'b1;
        end else if (w_bypass) begin
            w_sel_valid = 1'b1;
            w_sel_req   = w_mem_req;
            w_push      = 1'b0;
        end
    end

    wb_fifo u_wb_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_din     (w_mem_req),
        .o_dout_c  (w_head_req),
        .o_count   (w_fifo_count),
        .o_full_c  (w_fifo_full),
        .o_empty_c (w_fifo_empty)
    );

    // CDB and scoreboard clear registered together; idle cycles carry zeros
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cdb_valid   <= 1'b0;
            r_cdb         <= '0;
            r_clear_valid <= '0;
            r_clear_scb   <= '0;
        end else begin
            r_cdb_valid   <= w_sel_valid;
            r_cdb         <= w_sel_req;
            r_clear_valid <= warp_onehot(w_sel_req.warp_id, w_sel_valid);
            r_clear_scb   <= w_sel_req.scb_id;
        end
    end

    assign cdb_valid          = r_cdb_valid;
    assign cdb_warp_id        = r_cdb.warp_id;
    assign cdb_dst            = r_cdb.dst;
    assign cdb_mask           = r_cdb.mask;
    assign cdb_data           = r_cdb.data;
    assign clear_valid_regwr  = r_clear_valid;
    assign clear_scb_id_regwr = r_clear_scb;
    assign fifo_count         = w_fifo_count;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Self-checking bench for cdb_writeback_arbiter: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_cdb_writeback_arbiter;
    import gpu_pkg::*;

`ifdef CDB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                  clk;
    logic                  rst;
    logic                  alu_valid;
    logic [WARP_ID_W-1:0]  alu_warp_id;
    logic [SCB_ID_W-1:0]   alu_scb_id;
    logic [REG_ID_W-1:0]   alu_dst;
    logic [NUM_LANES-1:0]  alu_mask;
    logic [DATA_W-1:0]     alu_data;
    logic                  mem_valid;
    logic                  mem_ready;
    logic [WARP_ID_W-1:0]  mem_warp_id;
    logic [SCB_ID_W-1:0]   mem_scb_id;
    logic [REG_ID_W-1:0]   mem_dst;
    logic [NUM_LANES-1:0]  mem_mask;
    logic [DATA_W-1:0]     mem_data;
    logic                  cdb_valid;
    logic [WARP_ID_W-1:0]  cdb_warp_id;
    logic [REG_ID_W-1:0]   cdb_dst;
    logic [NUM_LANES-1:0]  cdb_mask;
    logic [DATA_W-1:0]     cdb_data;
    logic [NUM_WARPS-1:0]  clear_valid_regwr;
    logic [SCB_ID_W-1:0]   clear_scb_id_regwr;
    logic [FIFO_CNT_W-1:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: MEM results accepted but not yet written back
    wb_req_t q_mem[$];

    cdb_writeback_arbiter dut (
        .clk                (clk),
        .rst                (rst),
        .alu_valid          (alu_valid),
        .alu_warp_id        (alu_warp_id),
        .alu_scb_id         (alu_scb_id),
        .alu_dst            (alu_dst),
        .alu_mask           (alu_mask),
        .alu_data           (alu_data),
        .mem_valid          (mem_valid),
        .mem_ready          (mem_ready),
        .mem_warp_id        (mem_warp_id),
        .mem_scb_id         (mem_scb_id),
        .mem_dst            (mem_dst),
        .mem_mask           (mem_mask),
        .mem_data           (mem_data),
        .cdb_valid          (cdb_valid),
        .cdb_warp_id        (cdb_warp_id),
        .cdb_dst            (cdb_dst),
        .cdb_mask           (cdb_mask),
        .cdb_data           (cdb_data),
        .clear_valid_regwr  (clear_valid_regwr),
        .clear_scb_id_regwr (clear_scb_id_regwr),
        .fifo_count         (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic wb_req_t rand_req();
        wb_req_t r;
        r.warp_id = WARP_ID_W'($urandom);
        r.scb_id  = SCB_ID_W'($urandom);
        r.dst     = REG_ID_W'($urandom);
        r.mask    = NUM_LANES'($urandom);
        for (int i = 0; i < NUM_LANES; i++) r.data[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic wb_req_t mk_req(input int warp, input int scb, input int dst,
                                       input int mask);
        wb_req_t r;
        r = rand_req();
        r.warp_id = WARP_ID_W'(warp);
        r.scb_id  = SCB_ID_W'(scb);
        r.dst     = REG_ID_W'(dst);
        r.mask    = NUM_LANES'(mask);
        return r;
    endfunction

    function automatic wb_req_t idle_req();
        wb_req_t r;
        r = '0;
        return r;
    endfunction

    // One clock: drive inputs, predict, then check the registered result
    task automatic step(input bit av, input wb_req_t ar, input bit mv,
                        input wb_req_t mr, output bit acc);
        bit                   exp_v;
        wb_req_t              exp_r;
        logic [NUM_WARPS-1:0] exp_clr;
        alu_valid   = av;
        alu_warp_id = ar.warp_id;
        alu_scb_id  = ar.scb_id;
        alu_dst     = ar.dst;
        alu_mask    = ar.mask;
        alu_data    = ar.data;
        mem_valid   = mv;
        mem_warp_id = mr.warp_id;
        mem_scb_id  = mr.scb_id;
        mem_dst     = mr.dst;
        mem_mask    = mr.mask;
        mem_data    = mr.data;
        #1;
        check("mem_ready", mem_ready, q_mem.size() != FIFO_DEPTH);
        check("fifo_count", fifo_count, q_mem.size());
        acc   = mv && (q_mem.size() != FIFO_DEPTH);
        exp_v = 1'b1;
        exp_r = '0;
        if (av) exp_r = ar;
        else if (q_mem.size() > 0) exp_r = q_mem.pop_front();
        else if (BYPASS && acc) exp_r = mr;
        else exp_v = 1'b0;
        if (acc && !(BYPASS && exp_v && !av && exp_r == mr && q_mem.size() == 0
                     && !(q_mem.size() > 0)))
            q_mem.push_back(mr);
        else if (acc && av)
            q_mem.push_back(mr);
        exp_clr = '0;
        if (exp_v) exp_clr[exp_r.warp_id] = 1'b1;
        @(posedge clk);
        #1;
        check("cdb_valid", cdb_valid, exp_v);
        check("cdb_warp_id", cdb_warp_id, exp_r.warp_id);
        check("cdb_dst", cdb_dst, exp_r.dst);
        check("cdb_mask", cdb_mask, exp_r.mask);
        check("clear_valid_regwr", clear_valid_regwr, exp_clr);
        check("clear_scb_id_regwr", clear_scb_id_regwr, exp_r.scb_id);
        if (exp_v) check("cdb_data", cdb_data, exp_r.data);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, idle_req(), 1'b0, idle_req(), acc);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cdb_valid"}, cdb_valid, 1'b0);
        check({tag, "_clear_valid"}, clear_valid_regwr, '0);
        check({tag, "_clear_scb"}, clear_scb_id_regwr, '0);
        check({tag, "_cdb_dst"}, cdb_dst, '0);
        check({tag, "_fifo_count"}, fifo_count, '0);
        check({tag, "_mem_ready"}, mem_ready, 1'b1);
    endtask

    initial begin
        bit      acc;
        bit      av;
        bit      mv;
        wb_req_t mr;
        int      accepted;

        rst = 1'b0;
        alu_valid = 1'b0; alu_warp_id = '0; alu_scb_id = '0; alu_dst = '0;
        alu_mask = '0; alu_data = '0;
        mem_valid = 1'b0; mem_warp_id = '0; mem_scb_id = '0; mem_dst = '0;
        mem_mask = '0; mem_data = '0;
        @(posedge clk); @(posedge clk); #1;
        check_reset_state("reset");
        rst = 1'b1;

        // ALU only: warp 3, scb 2, dst 7
        step(1'b1, mk_req(3, 2, 7, 8'hff), 1'b0, idle_req(), acc);
        check("alu_only_clear", clear_valid_regwr, 8'b0000_1000);
        idle(1);

        // Collision: ALU warp 1 wins, MEM warp 5 follows a cycle later
        step(1'b1, mk_req(1, 1, 4, 8'h0f), 1'b1, mk_req(5, 0, 9, 8'hf0), acc);
        step(1'b0, idle_req(), 1'b0, idle_req(), acc);
        check("collision_mem_clear", clear_valid_regwr, 8'b0010_0000);
        idle(2);

        // Backpressure: 6 ALU cycles with MEM held valid, then drain
        mr = rand_req();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, rand_req(), 1'b1, mr, acc);
            if (acc) mr = rand_req();
        end
        check("backpressure_count", fifo_count, FIFO_CNT_W'(FIFO_DEPTH));
        check("backpressure_ready", mem_ready, 1'b0);
        idle(6);

        // Wrap-around: 10 MEM results against alternating ALU bursts
        accepted = 0;
        mr = rand_req();
        for (int c = 0; c < 200 && accepted < 10; c++) begin
            av = ((c / 3) % 2) == 0;
            step(av, rand_req(), 1'b1, mr, acc);
            if (acc) begin
                accepted++;
                mr = rand_req();
            end
        end
        check("wrap_accepted", accepted, 10);
        idle(6);

        // Zero mask still retires scoreboard entry 3
        step(1'b0, idle_req(), 1'b1, mk_req(6, 3, 12, 0), acc);
        idle(2);

        // Reset with three buffered MEM results
        for (int i = 0; i < 3; i++) step(1'b1, rand_req(), 1'b1, rand_req(), acc);
        check("pre_reset_count", fifo_count, 3);
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        rst = 1'b0;
        #1;
        check_reset_state("midrst");
        @(posedge clk); #1;
        check_reset_state("midrst_hold");
        q_mem.delete();
        rst = 1'b1;
        idle(3);

        // Randomized traffic; MEM producer holds its offer until accepted
        mr = rand_req();
        for (int c = 0; c < 400; c++) begin
            av = $urandom_range(0, 99) < 45;
            mv = $urandom_range(0, 99) < 60;
            step(av, rand_req(), mv, mr, acc);
            if (acc) mr = rand_req();
        end
        idle(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
